pcap_rec_hdr_gen: RTL and testbench
===================================

Name: pcap_rec_hdr_gen

Overview:
Consumes the free-running seconds/nanoseconds timestamp and per-packet start/end strobes from the capture path. Produces one 16-byte pcap record header per captured packet as four 32-bit words on a valid/ready stream. Sits between the timestamp counter and the pcap writer. Uses nanosecond-resolution pcap format, so no division is needed.

Parameters:
SNAPLEN, 1518, maximum captured bytes per packet; incl_len is clamped to this value.
DEPTH, 4, number of completed headers that can be queued; must be a power of two and at least 2.
LEN_W, 16, width of the packet length inputs.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ts_seconds  in  32  current seconds from the timestamp counter
ts_nanoseconds  in  32  current nanoseconds from the timestamp counter
pkt_sop  in  1  one-cycle pulse on the first beat of a packet
pkt_eop  in  1  one-cycle pulse on the last beat of a packet
pkt_len  in  LEN_W  original packet length in bytes; valid while pkt_eop is high
hdr_data  out  32  header word
hdr_valid  out  1  hdr_data is valid
hdr_ready  in  1  downstream accepts the word
hdr_last  out  1  marks word 3 (orig_len) of the header
pkt_open  out  1  a sop has been latched and its eop has not yet arrived
overflow  out  1  sticky flag: a header was dropped because the queue was full
drop_cnt  out  16  saturating count of dropped headers

Behaviour:
- Reset: all outputs 0, queue empty, output FSM in IDLE, latched timestamp 0. Reset mid-header discards the queue and the partial header; no further words are emitted.
- Capture
  - On pkt_sop, latch {ts_seconds, ts_nanoseconds} from the same cycle and set pkt_open.
  - A pkt_sop while pkt_open is set re-latches the timestamp; the previous packet is abandoned silently.
- Completion
  - On pkt_eop with pkt_open set, push {sec, nsec, incl_len, orig_len} and clear pkt_open.
  - orig_len = zero-extended pkt_len.
  - incl_len = min(pkt_len, SNAPLEN).
- pkt_eop with pkt_open clear and pkt_sop low: ignored, nothing is pushed.
- pkt_sop and pkt_eop in the same cycle:
  - If pkt_open is set: the eop closes the open packet using its latched timestamp, then the sop opens a new packet with the current timestamp. pkt_open stays 1.
  - If pkt_open is clear: this is a single-beat packet. Push using the current-cycle timestamp. pkt_open stays 0.
- Queue full at push: drop the entry, set overflow, and increment drop_cnt, saturating at 0xFFFF. A push and a pop of the final word in the same cycle with a full queue is accepted, not dropped.
- Output FSM
  - States: IDLE, W_SEC, W_NSEC, W_INCL, W_ORIG.
  - IDLE moves to W_SEC when the queue is non-empty.
  - Each state advances on hdr_valid && hdr_ready.
  - W_ORIG drives hdr_last=1, pops the entry on handshake, and goes to W_SEC if the queue is still non-empty, otherwise to IDLE.
  - No idle cycle is inserted between back-to-back headers.
- Handshake
  - hdr_valid is asserted in every W_* state.
  - hdr_data and hdr_last are stable while hdr_valid && !hdr_ready.
  - hdr_valid does not depend combinationally on hdr_ready.
- Latency: with the queue empty and the FSM in IDLE, pkt_eop in cycle N gives hdr_valid=1 carrying sec in cycle N+1. With ready held high, the last word is in cycle N+4.
- Word order: sec, nsec, incl_len, orig_len. Host byte-order conversion is done by the downstream writer.

Decomposition:
- pcap_pkg holds:
  - typedef rec_hdr_t struct {sec, nsec, incl_len, orig_len}, each 32 bits.
  - PCAP_HDR_WORDS = 4.
  - PCAP_MAGIC_NS = 32'hA1B23C4D.
  - the output FSM state enum.
- Sub-module sync_fifo: parameterised by width and depth, with registered full/empty and a same-cycle push/pop-when-full rule. Instantiate it with rec_hdr_t and DEPTH.

Test Plan:
1. Basic header:
   - Stimulus: ts=(5, 960) at sop; eop 3 cycles later with pkt_len=64; hdr_ready=1.
   - Response: words 5, 960, 64, 64 in cycles N+1..N+4; hdr_last only on the 4th word.
2. Snap clamp:
   - Stimulus: pkt_len=9000 with SNAPLEN=1518.
   - Response: incl_len=1518, orig_len=9000.
3. Backpressure:
   - Stimulus: hdr_ready toggling 1,0,0,1,...
   - Response: each word is held stable while stalled, exactly 4 handshakes occur, and the sequence is unchanged.
4. Overflow (DEPTH=4):
   - Stimulus: hdr_ready=0; 6 sop/eop pairs.
   - Response: 4 headers queued, overflow=1, drop_cnt=2. After releasing ready, 16 words emerge in order.
5. Coincident strobes:
   - Stimulus: packet A opened at ts=(1, 100); sop+eop in the same cycle at ts=(1, 200); eop later with len=80.
   - Response: header A carries (1, 100); header B carries (1, 200) with len 80.
6. Reset mid-stream:
   - Stimulus: assert reset while in W_NSEC with 2 entries queued.
   - Response: next cycle hdr_valid=0, overflow=0, drop_cnt=0, pkt_open=0. No stale words after reset is released.

Source files
------------

// File: rtl/pcap_pkg.sv
// Shared types for the pcap record header generator: header layout and
// output sequencer states.
package pcap_pkg;

    localparam int          PCAP_HDR_WORDS = 4;
    localparam logic [31:0] PCAP_MAGIC_NS  = 32'hA1B23C4D;

    typedef struct packed {
        logic [31:0] sec;
        logic [31:0] nsec;
        logic [31:0] incl_len;
        logic [31:0] orig_len;
    } rec_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_SEC,
        ST_W_NSEC,
        ST_W_INCL,
        ST_W_ORIG
    } hdr_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags. When full, a push is
// still accepted if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     push_ok,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic [AW:0]      count_nxt;

    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + 1'b1;
        else if (!push_ok && pop_ok)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/pcap_rec_hdr_gen.sv
// Builds one 16-byte nanosecond pcap record header per captured packet and
// streams it out as four 32-bit words: sec, nsec, incl_len, orig_len.
module pcap_rec_hdr_gen
    import pcap_pkg::*;
#(
    parameter int SNAPLEN = 1518,
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ts_seconds,
    input  logic [31:0]      ts_nanoseconds,
    input  logic             pkt_sop,
    input  logic             pkt_eop,
    input  logic [LEN_W-1:0] pkt_len,
    output logic [31:0]      hdr_data,
    output logic             hdr_valid,
    input  logic             hdr_ready,
    output logic             hdr_last,
    output logic             pkt_open,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [31:0] SNAP     = 32'(SNAPLEN);

    logic [31:0]   lat_sec;
    logic [31:0]   lat_nsec;
    logic [31:0]   len32;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    rec_hdr_t      push_entry;
    rec_hdr_t      head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    hdr_state_e    state, state_nxt;

    // An eop closes either the open packet or a single-beat sop+eop packet.
    always_comb begin
        len32               = 32'(pkt_len);
        push_req            = pkt_eop && (pkt_open || pkt_sop);
        push_entry.sec      = pkt_open ? lat_sec  : ts_seconds;
        push_entry.nsec     = pkt_open ? lat_nsec : ts_nanoseconds;
        push_entry.incl_len = (len32 > SNAP) ? SNAP : len32;
        push_entry.orig_len = len32;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_open <= 1'b0;
            lat_sec  <= '0;
            lat_nsec <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (pkt_sop && !(pkt_eop && !pkt_open)) begin
                lat_sec  <= ts_seconds;
                lat_nsec <= ts_nanoseconds;
                pkt_open <= 1'b1;
            end else if (pkt_eop) begin
                pkt_open <= 1'b0;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(rec_hdr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_entry),
        .push_ok   (push_ok),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // IDLE looks at the incoming push so sec appears the cycle after eop.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!fifo_empty || push_ok) state_nxt = ST_W_SEC;
            ST_W_SEC:  if (hdr_ready) state_nxt = ST_W_NSEC;
            ST_W_NSEC: if (hdr_ready) state_nxt = ST_W_INCL;
            ST_W_INCL: if (hdr_ready) state_nxt = ST_W_ORIG;
            ST_W_ORIG: if (hdr_ready)
                           state_nxt = (fifo_count > CNT_ONE || push_ok) ? ST_W_SEC : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        hdr_valid = (state != ST_IDLE);
        hdr_last  = (state == ST_W_ORIG);
        pop       = (state == ST_W_ORIG) && hdr_ready;
        case (state)
            ST_W_SEC:  hdr_data = head.sec;
            ST_W_NSEC: hdr_data = head.nsec;
            ST_W_INCL: hdr_data = head.incl_len;
            ST_W_ORIG: hdr_data = head.orig_len;
            default:   hdr_data = '0;
        endcase
    end

endmodule

// File: tb/tb_pcap_rec_hdr_gen.sv
// Random and directed stimulus for pcap_rec_hdr_gen, checked every cycle
// against a word-queue reference model.
module tb_pcap_rec_hdr_gen;

    localparam int SNAPLEN = 1518;
    localparam int DEPTH   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ts_seconds, ts_nanoseconds;
    logic        pkt_sop, pkt_eop;
    logic [15:0] pkt_len;
    logic [31:0] hdr_data;
    logic        hdr_valid, hdr_ready, hdr_last;
    logic        pkt_open, overflow;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] mq[$];
    bit          m_open = 0;
    logic [31:0] m_sec = 0, m_nsec = 0;
    bit          m_ovf = 0;
    int          m_drops = 0;

    pcap_rec_hdr_gen #(.SNAPLEN(SNAPLEN), .DEPTH(DEPTH), .LEN_W(16)) dut (
        .clk(clk), .reset(reset),
        .ts_seconds(ts_seconds), .ts_nanoseconds(ts_nanoseconds),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_len(pkt_len),
        .hdr_data(hdr_data), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_last(hdr_last), .pkt_open(pkt_open),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(hdr_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("data", hdr_data, mq[0]);
            chk("last", 32'(hdr_last), 32'(mq.size() % 4 == 1));
        end
        chk("open", 32'(pkt_open), 32'(m_open));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        chk("drops", 32'(drop_cnt), 32'(m_drops));
    endtask

    // One clock: check current outputs, apply inputs, advance the model.
    task automatic cyc(input bit rst, input bit sop, input bit eop, input int len,
                       input logic [31:0] s, input logic [31:0] ns, input bit rdy);
        bit          hs, last_hs;
        int          nhdr;
        logic [31:0] hs_sec, hs_nsec, incl;
        check_outputs();
        reset = rst; pkt_sop = sop; pkt_eop = eop; pkt_len = len[15:0];
        ts_seconds = s; ts_nanoseconds = ns; hdr_ready = rdy;
        if (rst) begin
            mq.delete(); m_open = 0; m_sec = 0; m_nsec = 0; m_ovf = 0; m_drops = 0;
        end else begin
            hs      = (mq.size() > 0) && rdy;
            last_hs = hs && (mq.size() % 4 == 1);
            nhdr    = (mq.size() + 3) / 4;
            if (hs) void'(mq.pop_front());
            if (eop && (m_open || sop)) begin
                hs_sec  = m_open ? m_sec  : s;
                hs_nsec = m_open ? m_nsec : ns;
                incl    = (len > SNAPLEN) ? SNAPLEN : len;
                if (nhdr < DEPTH || last_hs) begin
                    mq.push_back(hs_sec); mq.push_back(hs_nsec);
                    mq.push_back(incl);   mq.push_back(32'(len));
                end else begin
                    m_ovf = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (sop && eop && !m_open) begin
                // single-beat packet: nothing stays open
            end else if (sop) begin
                m_open = 1; m_sec = s; m_nsec = ns;
            end else if (eop) begin
                m_open = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 32'd7, 32'd7, rdy);
    endtask

    initial begin
        bit [3:0] rpat;
        logic [31:0] rs, rns;
        reset = 1; pkt_sop = 0; pkt_eop = 0; pkt_len = 0;
        ts_seconds = 0; ts_nanoseconds = 0; hdr_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // reset state
        chk("rst_valid", 32'(hdr_valid), 32'd0);
        chk("rst_open", 32'(pkt_open), 32'd0);
        chk("rst_drops", 32'(drop_cnt), 32'd0);

        // basic header
        cyc(0, 1, 0, 0, 32'd5, 32'd960, 1);
        idle(2, 1);
        cyc(0, 0, 1, 64, 32'd6, 32'd0, 1);
        chk("t1_sec", hdr_data, 32'd5);
        cyc(0, 0, 0, 0, 32'd6, 32'd1, 1);
        chk("t1_nsec", hdr_data, 32'd960);
        idle(5, 1);

        // snap clamp
        cyc(0, 1, 0, 0, 32'd9, 32'd9, 1);
        cyc(0, 0, 1, 9000, 32'd9, 32'd10, 1);
        idle(2, 1);
        chk("t2_incl", hdr_data, 32'd1518);
        idle(1, 1);
        chk("t2_orig", hdr_data, 32'd9000);
        idle(3, 1);

        // backpressure
        rpat = 4'b1001;
        cyc(0, 1, 0, 0, 32'd11, 32'd111, 0);
        cyc(0, 0, 1, 200, 32'd11, 32'd112, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, 0, 32'd11, 32'd113, rpat[i % 4]);

        // overflow
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0, 32'd20 + i, 32'd100 + i, 0);
            cyc(0, 0, 1, 60 + i, 32'd0, 32'd0, 0);
        end
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_drops", 32'(drop_cnt), 32'd2);
        idle(20, 1);

        // coincident strobes
        cyc(0, 1, 0, 0, 32'd1, 32'd100, 1);
        idle(1, 1);
        cyc(0, 1, 1, 50, 32'd1, 32'd200, 1);
        idle(1, 1);
        cyc(0, 0, 1, 80, 32'd1, 32'd300, 1);
        idle(10, 1);

        // reset while a header is mid-stream
        cyc(0, 1, 0, 0, 32'd30, 32'd1, 0);
        cyc(0, 0, 1, 70, 32'd30, 32'd2, 0);
        cyc(0, 1, 0, 0, 32'd31, 32'd3, 0);
        cyc(0, 0, 1, 71, 32'd31, 32'd4, 1);
        cyc(0, 0, 0, 0, 32'd31, 32'd5, 0);
        cyc(1, 0, 0, 0, 32'd31, 32'd6, 1);
        chk("t6_valid", 32'(hdr_valid), 32'd0);
        chk("t6_open", 32'(pkt_open), 32'd0);
        idle(8, 1);

        // random traffic
        rs = 32'd1000;
        for (int i = 0; i < 3000; i++) begin
            rs  = rs + 32'($urandom_range(0, 1));
            rns = $urandom_range(0, 999999999);
            cyc(($urandom_range(0, 499) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(40, 2000)),
                rs, rns,
                ($urandom_range(0, 9) < 7));
        end
        idle(40, 1);
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
